// File: rtl/toptop_mixer.sv
// toptop_mixer: three-voice square-wave synthesiser with a first-order
// sigma-delta modulator producing a 1-bit audio stream.
//
// Ports:
//   clk           system clock, rising-edge active
//   rst           asynchronous reset, active-high
//   in1..in3      voice half-periods in clk cycles (0 mutes the voice),
//                 sampled only on the falling edge of bandera
//   bandera       load/restart strobe; while high, voices and modulator
//                 are held cleared; its falling edge loads new periods
//   salida_audio  registered 1-bit sigma-delta output
module toptop_mixer (
  input  logic        clk,
  input  logic        rst,
  input  logic [28:0] in1,
  input  logic [28:0] in2,
  input  logic [28:0] in3,
  input  logic        bandera,
  output logic        salida_audio
);

  logic [2:0][28:0] p_q, p_d;
  logic [2:0][28:0] c_q, c_d;
  logic [2:0]       s_q, s_d;
  logic [1:0]       acc_q, acc_d;
  logic             bandera_d_q;
  logic             salida_q, salida_d;

  logic [1:0] sum;
  logic [2:0] t;
  logic [2:0] t_m3;

  always_comb begin
    sum  = {1'b0, s_q[0]} + {1'b0, s_q[1]} + {1'b0, s_q[2]};
    t    = {1'b0, acc_q} + {1'b0, sum};
    t_m3 = t - 3'd3;

    p_d      = p_q;
    c_d      = c_q;
    s_d      = s_q;
    acc_d    = acc_q;
    salida_d = 1'b0;

    if (bandera) begin
      c_d   = '0;
      s_d   = '0;
      acc_d = '0;
    end else if (bandera_d_q) begin
      // Falling edge of the strobe: the only moment the inputs are observed.
      p_d   = {in3, in2, in1};
      c_d   = '0;
      s_d   = '0;
      acc_d = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (p_q[i] == 29'd0) begin
          c_d[i] = '0;
          s_d[i] = 1'b0;
        end else if (c_q[i] == p_q[i] - 29'd1) begin
          // Compare against P-1 so the counter never exceeds P-1,
          // which keeps the all-ones period free of overflow.
          c_d[i] = '0;
          s_d[i] = ~s_q[i];
        end else begin
          c_d[i] = c_q[i] + 29'd1;
        end
      end

      // Quantise against 3 (the full-scale mix); the residue carries
      // forward so the output density tracks SUM/3.
      if (t >= 3'd3) begin
        salida_d = 1'b1;
        acc_d    = t_m3[1:0];
      end else begin
        salida_d = 1'b0;
        acc_d    = t[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= '0;
      c_q         <= '0;
      s_q         <= '0;
      acc_q       <= '0;
      bandera_d_q <= 1'b0;
      salida_q    <= 1'b0;
    end else begin
      p_q         <= p_d;
      c_q         <= c_d;
      s_q         <= s_d;
      acc_q       <= acc_d;
      bandera_d_q <= bandera;
      salida_q    <= salida_d;
    end
  end

  assign salida_audio = salida_q;

endmodule

// File: tb/tb_toptop_mixer.sv
// Directed self-checking bench for toptop_mixer.
module tb_toptop_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic [28:0] in1, in2, in3;
  logic        bandera;
  logic        salida_audio;

  int n_checks = 0;
  int n_pass   = 0;
  int ones;
  int bad;

  toptop_mixer dut (
    .clk          (clk),
    .rst          (rst),
    .in1          (in1),
    .in2          (in2),
    .in3          (in3),
    .bandera      (bandera),
    .salida_audio (salida_audio)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ins();
    in1 = 29'($urandom());
    in2 = 29'($urandom());
    in3 = 29'($urandom());
  endtask

  // Hold bandera high for len edges (inputs randomised meanwhile), then
  // present a,b,c and drop bandera; returns just after the load edge.
  task automatic pulse(input logic [28:0] a, input logic [28:0] b,
                       input logic [28:0] c, input int len);
    bandera = 1'b1;
    for (int k = 0; k < len; k++) begin
      rand_ins();
      step();
    end
    in1 = a;
    in2 = b;
    in3 = c;
    bandera = 1'b0;
    step();
    rand_ins();
  endtask

  task automatic count_ones(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (salida_audio === 1'b1) cnt++;
    end
  endtask

  logic [11:0] pat_inphase = 12'b110011001100;  // bit k-1 = edge L+k
  logic [11:0] pat_restart = 12'b110001001000;

  initial begin
    // Reset with hostile inputs and bandera high.
    rst = 1'b1;
    bandera = 1'b1;
    rand_ins();
    #1;
    check("reset_out", salida_audio, 0);
    step();
    step();
    bandera = 1'b0;
    #2;
    rst = 1'b0;
    count_ones(1000, ones);
    check("post_reset_silent", ones, 0);

    // All voices muted.
    pulse(29'd0, 29'd0, 29'd0, 1);
    count_ones(200, ones);
    check("mute", ones, 0);

    // In-phase voices, inputs scrambled after the load.
    pulse(29'd2, 29'd2, 29'd2, 1);
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("inphase_L+%0d", k + 1), salida_audio, pat_inphase[k]);
    end

    // Asynchronous reset mid-operation discards the loaded periods.
    rst = 1'b1;
    #1;
    check("midop_reset_out", salida_audio, 0);
    step();
    #2;
    rst = 1'b0;
    count_ones(1000, ones);
    check("periods_discarded", ones, 0);

    // Single voice at P=1 via a long strobe; only the final value loads.
    pulse(29'd1, 29'd0, 29'd0, 4);
    count_ones(60, ones);
    check("single_voice_60", ones, 10);

    // Three tones over one LCM window.
    pulse(29'd11, 29'd4, 29'd9, 1);
    count_ones(792, ones);
    check("three_tones_lo", (ones >= 395) ? 1 : 0, 1);
    check("three_tones_hi", (ones <= 397) ? 1 : 0, 1);

    // Restart: run P1=32, hold bandera 50 cycles, then reload.
    pulse(29'd32, 29'd0, 29'd0, 1);
    count_ones(100, ones);
    check("p32_density", (ones >= 12 && ones <= 22) ? 1 : 0, 1);
    bandera = 1'b1;
    in1 = 29'd32;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (salida_audio !== 1'b0) bad++;
    end
    check("bandera_high_out", bad, 0);
    in1 = 29'd2;
    in2 = 29'd2;
    in3 = 29'd1 << 20;
    bandera = 1'b0;
    step();
    rand_ins();
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("restart_L+%0d", k + 1), salida_audio, pat_restart[k]);
    end

    // Largest period: no toggle within a short window.
    pulse(29'h1FFF_FFFF, 29'd0, 29'd0, 2);
    count_ones(300, ones);
    check("max_period_quiet", ones, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/toptop_mixer.md
TOPTOP_MIXER -- requirements
Module: toptop

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all sequential logic updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in1  input  29  voice-1 half-period in clk cycles, unsigned; 0 mutes the voice.
REQ-005 in2  input  29  voice-2 half-period, same encoding as in1.
REQ-006 in3  input  29  voice-3 half-period, same encoding as in1.
REQ-007 bandera  input  1  synchronous load/restart strobe, active-high, level-sensitive.
REQ-008 salida_audio  output  1  registered 1-bit sigma-delta audio stream.

Function
REQ-009 The block SHALL hold three 29-bit period registers P1..P3, three 29-bit counters C1..C3, three square-wave bits S1..S3, a 2-bit accumulator ACC, and a 1-bit register bandera_d.
REQ-010 bandera_d SHALL register bandera every cycle.
REQ-011 While bandera=1: C1..C3, S1..S3 and ACC SHALL clear to 0 on each edge; P1..P3 SHALL hold; salida_audio SHALL register 0.
REQ-012 On the first cycle with bandera=0 and bandera_d=1 (falling-edge detect), P1..P3 SHALL load in1..in3 sampled at that edge; C, S and ACC SHALL stay 0 on that edge.
REQ-013 in1..in3 SHALL have no effect at any other time.
REQ-014 For each voice with Pi=0: Ci and Si SHALL stay 0.
REQ-015 For each voice with Pi≥1: if Ci = Pi-1, Ci SHALL return to 0 and Si SHALL toggle; otherwise Ci SHALL increment by 1.
REQ-016 Each active voice SHALL therefore output a square wave with period 2*Pi cycles.
REQ-017 Pi=1 SHALL toggle Si every cycle.
REQ-018 The maximum value Pi = 2^29-1 SHALL work without counter overflow.
REQ-019 Mix: SUM = S1+S2+S3 (2-bit, range 0..3).
REQ-020 Modulator: T = ACC+SUM (3-bit). If T≥3, salida_audio SHALL register 1 and ACC SHALL become T-3; otherwise salida_audio SHALL register 0 and ACC SHALL become T.
REQ-021 ACC SHALL always stay within 0..2.
REQ-022 The density of 1s on salida_audio SHALL equal the mean of SUM/3.
REQ-023 Latency: a change in S registers SHALL affect salida_audio on the next edge (1 cycle).
REQ-024 Simultaneous events: rst SHALL override bandera; the bandera clear of REQ-011 SHALL override the counting of REQ-015 in the same cycle.
REQ-025 A bandera pulse of any length ≥1 cycle SHALL produce exactly one load, at its falling edge.

Reset
REQ-026 rst=1 SHALL asynchronously clear to 0: P1..P3, C1..C3, S1..S3, ACC, bandera_d and salida_audio.
REQ-027 After reset, all voices SHALL be muted and salida_audio SHALL be 0 until a load occurs with a nonzero period.
REQ-028 Reset asserted mid-operation SHALL discard the loaded periods.

Verification
REQ-029 Reset: drive rst=1 with random inputs and bandera=1 → salida_audio=0 immediately; after release, salida_audio stays 0 for 1000 cycles with no load.
REQ-030 Mute: load in1=in2=in3=0 via a 1-cycle bandera pulse → salida_audio constant 0.
REQ-031 In-phase voices: load in1=in2=in3=2 → S waves coincide; salida_audio = 0,0,1,1 repeating (period 4 cycles), starting 1 cycle after the first toggle, with ACC constant 0.
REQ-032 Single voice: load in1=1, in2=in3=0 → exactly 1 one per 6 cycles on salida_audio.
REQ-033 Three tones: load in1=11, in2=4, in3=9 → over any 792-cycle window (LCM of 22, 8 and 18) after the load, salida_audio contains 396 ones ±1.
REQ-034 Restart mid-operation: with in1=32 active, hold bandera=1 for 50 cycles, then drop it with in3=2^20 → C and S are cleared while bandera is high; new periods take effect from the falling-edge cycle; salida_audio is 0 while bandera is high.
